// File: rtl/z_core_arb_pkg.sv
// Shared types and constants for the Z-Core two-port memory arbiter.
package z_core_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } arb_state_e;

    // One-hot per-port strobe for the given port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/z_core_mem_arbiter_if.sv
// Requester-side req/gnt/done bus of the Z-Core memory arbiter.
interface z_core_mem_arbiter_if
    import z_core_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, done, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/z_core_arb_pick.sv
// Combinational 2-way winner selector.
// Tie policy: round-robin against `last` when Z_CORE_ARB_RR_EN is defined,
// otherwise fixed priority with the core port winning every tie.
module z_core_arb_pick
    import z_core_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    logic tie_winner_c;

`ifdef Z_CORE_ARB_RR_EN
    assign tie_winner_c = ~last;
`else
    logic unused_last;
    assign unused_last  = last;
    assign tie_winner_c = PORT_CORE;
`endif

    // A lone requester always wins; a tie is resolved by the policy above.
    always_comb begin
        valid  = |req;
        winner = PORT_CORE;
        case (req)
            2'b10:   winner = PORT_AUX;
            2'b11:   winner = tie_winner_c;
            default: winner = PORT_CORE;
        endcase
    end

endmodule

// File: rtl/z_core_mem_arbiter.sv
// Shares the single-port Z-Core SRAM between the core (m0) and an auxiliary
// requester (m1). Each grant drives the memory for one cycle; done/rdata
// follow one cycle later while the next arbitration already runs.
// Optional macro Z_CORE_ARB_RR_EN selects round-robin tie breaking.
module z_core_mem_arbiter
    import z_core_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
)
(
    input  logic                clk,
    input  logic                rst_n,
    z_core_mem_arbiter_if.slave m0,
    z_core_mem_arbiter_if.slave m1,
    output logic                mem_en,
    output logic                mem_write_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data_out,
    input  logic [DATA_W-1:0]   mem_data_in
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;

    logic              pick_valid_c;
    logic              pick_winner_c;

    z_core_arb_pick u_pick (
        .req    ({m1.req, m0.req}),
        .last   (last_q),
        .valid  (pick_valid_c),
        .winner (pick_winner_c)
    );

    // Next state, command latch and next-cycle strobes.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE, RESP: begin
                // Requests seen in RESP are already new ones.
                if (pick_valid_c) begin
                    state_d = ACCESS;
                    owner_d = pick_winner_c;
                    last_d  = pick_winner_c;
                    if (pick_winner_c == PORT_AUX) begin
                        we_d    = m1.we;
                        addr_d  = m1.addr;
                        wdata_d = m1.wdata;
                    end else begin
                        we_d    = m0.we;
                        addr_d  = m0.addr;
                        wdata_d = m0.wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase

        mem_en_d = (state_d == ACCESS);
        mem_we_d = (state_d == ACCESS) && we_d;
        gnt_d    = (state_d == ACCESS) ? port_onehot(owner_d) : 2'b00;
        done_d   = (state_d == RESP)   ? port_onehot(owner_d) : 2'b00;
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= PORT_CORE;
            last_q   <= PORT_AUX;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_write_en = mem_we_q;
    assign mem_addr     = addr_q;
    assign mem_data_out = wdata_q;

    assign m0.gnt  = gnt_q[0];
    assign m1.gnt  = gnt_q[1];
    assign m0.done = done_q[0];
    assign m1.done = done_q[1];

    // SRAM data arrives in the RESP cycle, so it is steered rather than re-registered.
    assign m0.rdata = done_q[0] ? mem_data_in : '0;
    assign m1.rdata = done_q[1] ? mem_data_in : '0;

endmodule

// File: tb/tb_z_core_mem_arbiter.sv
// Self-checking bench for z_core_mem_arbiter with a small synchronous SRAM model.
module tb_z_core_mem_arbiter;

`ifdef Z_CORE_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_en, mem_write_en;
    logic [31:0] mem_addr, mem_data_out, mem_data_in;

    z_core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    z_core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

    z_core_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0           (m0_if),
        .m1           (m1_if),
        .mem_en       (mem_en),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: one-cycle read latency, read-before-write on a write access.
    logic        sram_init;
    logic [31:0] sram [16];
    logic [31:0] sram_q;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
            sram_q <= '0;
        end else if (mem_en) begin
            sram_q <= sram[mem_addr[5:2]];
            if (mem_write_en) sram[mem_addr[5:2]] <= mem_data_out;
        end
    end
    assign mem_data_in = sram_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] gnt, input logic [1:0] done,
                           input logic en, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdo, input logic [31:0] rd0, input logic [31:0] rd1);
        chk({tag, ".gnt"},   32'({m1_if.gnt, m0_if.gnt}),   32'(gnt));
        chk({tag, ".done"},  32'({m1_if.done, m0_if.done}), 32'(done));
        chk({tag, ".mem_en"}, 32'(mem_en),       32'(en));
        chk({tag, ".mem_we"}, 32'(mem_write_en), 32'(we));
        chk({tag, ".addr"},  mem_addr,     addr);
        chk({tag, ".wdata"}, mem_data_out, wdo);
        chk({tag, ".rdata0"}, m0_if.rdata, rd0);
        chk({tag, ".rdata1"}, m1_if.rdata, rd1);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    typedef struct {
        logic        r0, w0; logic [31:0] a0, d0;
        logic        r1, w1; logic [31:0] a1, d1;
        logic [1:0]  gnt, done;
        logic        en, we;
        logic [31:0] addr, wdo, rd0, rd1;
    } vec_t;

    vec_t vecs [10];

    // Random-phase reference state.
    logic [31:0] ref_mem [16];
    logic        m_busy, m_owner, m_last, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  pend;
    int          gnt_age [2];
    logic        p_we [2];
    logic [31:0] p_addr [2], p_wdata [2];

    initial begin
        // Row k: inputs held for one cycle, outputs expected after the next edge.
        vecs[0] = '{1,0,32'h10,0, 0,0,0,0,              2'b01,2'b00,1,0,32'h10,0,0,0};
        vecs[1] = '{1,0,32'h10,0, 0,0,0,0,              2'b00,2'b01,0,0,32'h10,0,32'hDEADBEEF,0};
        vecs[2] = '{0,0,0,0, 1,1,32'h20,32'h12345678,   2'b10,2'b00,1,1,32'h20,32'h12345678,0,0};
        vecs[3] = '{0,0,0,0, 1,1,32'h20,32'h12345678,   2'b00,2'b10,0,0,32'h20,32'h12345678,0,32'hA5A50008};
        vecs[4] = '{0,0,0,0, 0,0,0,0,                   2'b00,2'b00,0,0,32'h20,32'h12345678,0,0};
        vecs[5] = '{1,0,32'h20,0, 0,0,0,0,              2'b01,2'b00,1,0,32'h20,0,0,0};
        vecs[6] = '{1,0,32'h20,0, 0,0,0,0,              2'b00,2'b01,0,0,32'h20,0,32'h12345678,0};
        vecs[7] = '{1,0,32'h10,0, 0,0,0,0,              2'b01,2'b00,1,0,32'h10,0,0,0};
        vecs[8] = '{1,0,32'h10,0, 0,0,0,0,              2'b00,2'b01,0,0,32'h10,0,32'hDEADBEEF,0};
        vecs[9] = '{0,0,0,0, 0,0,0,0,                   2'b00,2'b00,0,0,32'h10,0,0,0};

        rst_n = 1'b0;
        sram_init = 1'b1;
        drive(0,0,0,0, 0,0,0,0);
        repeat (2) step();
        sram_init = 1'b0;
        chk_out("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Directed table: single reads/writes and back-to-back from RESP.
        for (int k = 0; k < 10; k++) begin
            drive(vecs[k].r0, vecs[k].w0, vecs[k].a0, vecs[k].d0,
                  vecs[k].r1, vecs[k].w1, vecs[k].a1, vecs[k].d1);
            step();
            chk_out($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].done, vecs[k].en, vecs[k].we,
                    vecs[k].addr, vecs[k].wdo, vecs[k].rd0, vecs[k].rd1);
        end

        // Continuous contention from reset: grant order follows the tie policy.
        do_reset();
        drive(1,0,32'h10,0, 1,0,32'h20,0);
        for (int s = 1; s <= 8; s++) begin
            int  j;
            logic p;
            step();
            j = (s - 1) / 2;
            p = RR_MODE ? 1'(j % 2) : 1'b0;
            if (s % 2 == 1) begin
                chk($sformatf("cont%0d.gnt", s), 32'({m1_if.gnt, m0_if.gnt}), 32'(onehot(p)));
                chk($sformatf("cont%0d.en", s), 32'(mem_en), 32'd1);
            end else begin
                chk($sformatf("cont%0d.done", s), 32'({m1_if.done, m0_if.done}), 32'(onehot(p)));
                chk($sformatf("cont%0d.en", s), 32'(mem_en), 32'd0);
            end
        end
        drive(0,0,0,0, 1,0,32'h20,0);
        step();
        chk("cont_drop0.gnt", 32'({m1_if.gnt, m0_if.gnt}), 32'(2'b10));
        step();
        drive(0,0,0,0, 0,0,0,0);
        step();

        // Asynchronous reset in the middle of a port-1 write access.
        drive(0,0,0,0, 1,1,32'h30,32'hCAFEF00D);
        step();
        chk("rstmid.pre_en", 32'(mem_en), 32'd1);
        chk("rstmid.pre_we", 32'(mem_write_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid.en", 32'(mem_en), 32'd0);
        chk("rstmid.we", 32'(mem_write_en), 32'd0);
        chk("rstmid.gnt1", 32'(m1_if.gnt), 32'd0);
        step();
        chk("rstmid.sram12", sram[12], init_word(12));
        drive(0,0,0,0, 0,0,0,0);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            chk($sformatf("rstmid.done%0d", s), 32'({m1_if.done, m0_if.done}), 32'd0);
        end
        drive(1,0,32'h10,0, 1,0,32'h20,0);
        step();
        chk("rstmid.first_gnt", 32'({m1_if.gnt, m0_if.gnt}), 32'(2'b01));

        // Idle for 10 cycles: strobes stay low, address holds.
        step();
        drive(0,0,0,0, 0,0,0,0);
        step();
        for (int s = 0; s < 10; s++) begin
            step();
            chk($sformatf("idle%0d.en", s), 32'(mem_en), 32'd0);
            chk($sformatf("idle%0d.addr", s), mem_addr, 32'h10);
        end

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = sram[i];
        m_busy = 0; m_owner = 0; m_last = 1; m_we = 0; m_addr = 0; m_wdata = 0;
        pend = 2'b00; gnt_age[0] = 0; gnt_age[1] = 0;
        for (int c = 0; c < 400; c++) begin
            logic [1:0]  e_gnt, e_done;
            logic        e_en, e_we, w;
            logic [31:0] e_rd0, e_rd1;
            for (int p = 0; p < 2; p++) begin
                if (gnt_age[p] == 2) begin pend[p] = 1'b0; gnt_age[p] = 0; end
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p]    = 1'b1;
                    p_we[p]    = 1'($urandom_range(0, 1));
                    p_addr[p]  = 32'($urandom_range(0, 15)) << 2;
                    p_wdata[p] = $urandom;
                end
            end
            drive(pend[0], p_we[0], p_addr[0], p_wdata[0], pend[1], p_we[1], p_addr[1], p_wdata[1]);

            e_gnt = 0; e_done = 0; e_en = 0; e_we = 0; e_rd0 = 0; e_rd1 = 0; w = 0;
            if (m_busy) begin
                e_done = onehot(m_owner);
                if (m_owner) e_rd1 = ref_mem[m_addr[5:2]];
                else         e_rd0 = ref_mem[m_addr[5:2]];
                if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
                m_busy = 0;
            end else if (pend != 2'b00) begin
                if (pend == 2'b11) w = RR_MODE ? ~m_last : 1'b0;
                else               w = pend[1];
                m_owner = w; m_last = w; m_busy = 1;
                m_we = p_we[w]; m_addr = p_addr[w]; m_wdata = p_wdata[w];
                e_gnt = onehot(w); e_en = 1; e_we = m_we;
            end

            step();
            for (int p = 0; p < 2; p++) if (gnt_age[p] != 0) gnt_age[p]++;
            if (e_gnt != 2'b00) gnt_age[w] = 1;
            chk_out($sformatf("rnd%0d", c), e_gnt, e_done, e_en, e_we, m_addr, m_wdata, e_rd0, e_rd1);
        end
        drive(0,0,0,0, 0,0,0,0);
        repeat (3) step();
        for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), sram[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
